// File: rtl/dvsd_cmp.sv
// Registered unsigned magnitude comparator: exactly one of less/equal/greater
// is high one cycle after the operands are sampled. All flags are low while in reset.
module dvsd_cmp #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             less_than,
    output logic             equal_to,
    output logic             greater_than
);

    logic lt_d, eq_d, gt_d;
    logic lt_q, eq_q, gt_q;

    // Scan LSB to MSB so the highest differing bit is the last writer and decides.
    always_comb begin
        lt_d = 1'b0;
        gt_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (A_in[i] != B_in[i]) begin
                gt_d = A_in[i];
                lt_d = B_in[i];
            end
        end
        eq_d = ~(lt_d | gt_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt_q <= 1'b0;
            eq_q <= 1'b0;
            gt_q <= 1'b0;
        end else begin
            lt_q <= lt_d;
            eq_q <= eq_d;
            gt_q <= gt_d;
        end
    end

    assign less_than    = lt_q;
    assign equal_to     = eq_q;
    assign greater_than = gt_q;

endmodule

// File: tb/tb_dvsd_cmp.sv
// Self-checking bench for dvsd_cmp (WIDTH=4): vector table, exhaustive sweep,
// reset and between-edge corner cases, with a queue of expected flag sets.
module tb_dvsd_cmp;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] A_in;
    logic [W-1:0] B_in;
    logic         less_than;
    logic         equal_to;
    logic         greater_than;

    dvsd_cmp #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .A_in         (A_in),
        .B_in         (B_in),
        .less_than    (less_than),
        .equal_to     (equal_to),
        .greater_than (greater_than)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flag sets are packed {lt, eq, gt}.
    localparam logic [2:0] LT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] GT = 3'b001;
    localparam logic [2:0] NONE = 3'b000;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   exp;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [2:0]  exp_q[$];

    function automatic logic [2:0] flags();
        return {less_than, equal_to, greater_than};
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got lt/eq/gt=%b, want %b", name, act, req);
        end
    endtask

    task automatic check_onehot(input string name);
        n_vec++;
        if (($countones(flags()) != 1) || $isunknown(flags())) begin
            n_err++;
            $display("FAIL %s onehot: got lt/eq/gt=%b", name, flags());
        end
    endtask

    task automatic pop_check(input string name);
        logic [2:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %b", name, flags());
        end else begin
            e = exp_q.pop_front();
            check(name, flags(), e);
            check_onehot(name);
        end
    endtask

    // Drive on the falling edge, expect the result just after the next rising edge.
    task automatic apply(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] e);
        @(negedge clk);
        A_in = a;
        B_in = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        pop_check(name);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{4'd8,  4'd9,  LT};
        vecs[1]  = '{4'd10, 4'd6,  GT};
        vecs[2]  = '{4'd2,  4'd2,  EQ};
        vecs[3]  = '{4'd15, 4'd14, GT};
        vecs[4]  = '{4'd3,  4'd7,  LT};
        vecs[5]  = '{4'd0,  4'd0,  EQ};
        vecs[6]  = '{4'd12, 4'd3,  GT};
        vecs[7]  = '{4'd0,  4'd15, LT};
        vecs[8]  = '{4'd15, 4'd0,  GT};
        vecs[9]  = '{4'd15, 4'd15, EQ};
        vecs[10] = '{4'd1,  4'd0,  GT};

        rst_n = 1'b0;
        A_in  = 4'd8;
        B_in  = 4'd9;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", flags(), NONE);

        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(LT);
        @(posedge clk);
        #1;
        pop_check("reset_release");

        for (int i = 0; i < 11; i++)
            apply($sformatf("vec%0d_%0d_%0d", i, vecs[i].a, vecs[i].b),
                  vecs[i].a, vecs[i].b, vecs[i].exp);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [2:0] e;
                e = (a < b) ? LT : ((a == b) ? EQ : GT);
                apply($sformatf("sweep_%0d_%0d", a, b), W'(a), W'(b), e);
            end
        end

        // Async reset between edges while greater_than is high.
        apply("pre_reset", 4'd12, 4'd3, GT);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", flags(), NONE);
        @(negedge clk);
        rst_n = 1'b1;
        A_in = 4'd5;
        B_in = 4'd5;
        exp_q.push_back(EQ);
        @(posedge clk);
        #1;
        pop_check("post_reset");

        // Input glitches between edges: only the value at the edge matters.
        apply("pre_glitch", 4'd2, 4'd9, LT);
        @(negedge clk);
        A_in = 4'd3;
        B_in = 4'd9;
        #1 A_in = 4'd14;
        #1 A_in = 4'd0;
        #1 A_in = 4'd9;
        exp_q.push_back(EQ);
        @(posedge clk);
        #1;
        pop_check("glitch_edge");
        A_in = 4'd15;
        #1 A_in = 4'd1;
        #1;
        check("glitch_hold", flags(), EQ);
        @(posedge clk);
        #1;
        check("glitch_next", flags(), LT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
